// File: rtl/fxp_alu_pipe.sv
// Pipelined saturating fixed-point ALU (signed two's-complement Q format) with a
// multiply-accumulate register and valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   input handshake; a bundle transfers when both are high
//   op, a, b, shift      opcode, signed operands, shift/rotate amount
//   out_valid, out_ready output handshake; a result transfers when both are high
//   result, sat, err     result word, clamping flag, illegal-opcode flag
//
// Register ranks: s1 (operands), s2 (raw full-width result), s3 (accumulator
// update), output (round + saturate). A bundle accepted at edge N is presented
// after edge N+3. Any output stall freezes every rank.
module fxp_alu_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC      = 15,
    parameter int unsigned SHIFT_W   = 4,
    parameter int unsigned ACC_GUARD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               sat,
    output logic               err
);

    localparam int unsigned AW = 2 * WIDTH + ACC_GUARD;

    localparam logic [3:0] OpNop = 4'd0, OpAdd = 4'd1, OpSub = 4'd2, OpMul = 4'd3;
    localparam logic [3:0] OpMac = 4'd4, OpAccRdClr = 4'd5, OpShra = 4'd6, OpShla = 4'd7;
    localparam logic [3:0] OpAnd = 4'd8, OpOr = 4'd9, OpXor = 4'd10, OpRol = 4'd11;
    localparam logic [3:0] OpRor = 4'd12;

    localparam logic [WIDTH-1:0] WMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] WMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [AW:0] WMaxWide = {{(AW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] WMinWide = {{(AW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [AW-1:0] AccMax = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] AccMin = {1'b1, {(AW-1){1'b0}}};
    // Round-half-up bias; zero when there are no fractional bits.
    localparam logic signed [AW:0] Half =
        (FRAC == 0) ? {(AW+1){1'b0}} : ({{AW{1'b0}}, 1'b1} << (FRAC - 1));

    // Pass: take low WIDTH bits as-is. Sat: clamp only. Round: round, then clamp.
    typedef enum logic [1:0] {KindPass, KindSat, KindRound} kind_e;

    logic stall, adv;
    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;

    // ---------------- S1: operand capture ----------------
    logic               s1_valid;
    logic [3:0]         s1_op;
    logic [WIDTH-1:0]   s1_a, s1_b;
    logic [SHIFT_W-1:0] s1_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_shift <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= op;
                s1_a     <= a;
                s1_b     <= b;
                s1_shift <= shift;
            end
        end
    end

    // ---------------- S2: raw full-width result ----------------
    logic [31:0]             sh;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH:0]   sum;
    logic [2*WIDTH-1:0]      shl_full;
    logic                    shl_ovf;
    logic signed [AW-1:0]    s2_raw_d;
    kind_e                   s2_kind_d;
    logic                    s2_sat_d, s2_err_d;

    always_comb begin
        sh       = 32'(s1_shift) % WIDTH;
        prod     = $signed(s1_a) * $signed(s1_b);
        sum      = (s1_op == OpSub)
                 ? $signed({s1_a[WIDTH-1], s1_a}) - $signed({s1_b[WIDTH-1], s1_b})
                 : $signed({s1_a[WIDTH-1], s1_a}) + $signed({s1_b[WIDTH-1], s1_b});
        shl_full = {{WIDTH{s1_a[WIDTH-1]}}, s1_a} << sh;
        // Overflow when any bit above the result differs from the result sign.
        shl_ovf  = shl_full[2*WIDTH-1:WIDTH] != {WIDTH{shl_full[WIDTH-1]}};

        s2_raw_d  = '0;
        s2_kind_d = KindPass;
        s2_sat_d  = 1'b0;
        s2_err_d  = 1'b0;
        case (s1_op)
            OpNop: ;
            OpAdd, OpSub: begin
                s2_raw_d  = AW'(sum);
                s2_kind_d = KindSat;
            end
            OpMul, OpMac, OpAccRdClr: begin
                s2_raw_d  = AW'(prod);
                s2_kind_d = KindRound;
            end
            OpShra: s2_raw_d[WIDTH-1:0] = $signed(s1_a) >>> sh;
            OpShla: begin
                s2_raw_d[WIDTH-1:0] = shl_ovf ? (s1_a[WIDTH-1] ? WMin : WMax)
                                              : shl_full[WIDTH-1:0];
                s2_sat_d = shl_ovf;
            end
            OpAnd: s2_raw_d[WIDTH-1:0] = s1_a & s1_b;
            OpOr:  s2_raw_d[WIDTH-1:0] = s1_a | s1_b;
            OpXor: s2_raw_d[WIDTH-1:0] = s1_a ^ s1_b;
            OpRol: s2_raw_d[WIDTH-1:0] = (s1_a << sh) | (s1_a >> (WIDTH - sh));
            OpRor: s2_raw_d[WIDTH-1:0] = (s1_a >> sh) | (s1_a << (WIDTH - sh));
            default: s2_err_d = 1'b1;
        endcase
    end

    logic                 s2_valid;
    logic [3:0]           s2_op;
    logic signed [AW-1:0] s2_raw;
    kind_e                s2_kind;
    logic                 s2_sat, s2_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_op    <= '0;
            s2_raw   <= '0;
            s2_kind  <= KindPass;
            s2_sat   <= 1'b0;
            s2_err   <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_op   <= s1_op;
                s2_raw  <= s2_raw_d;
                s2_kind <= s2_kind_d;
                s2_sat  <= s2_sat_d;
                s2_err  <= s2_err_d;
            end
        end
    end

    // ---------------- S3: accumulator ----------------
    logic signed [AW-1:0] acc_q;
    logic signed [AW:0]   acc_sum;
    logic                 acc_ovf;
    logic signed [AW-1:0] acc_new;
    logic signed [AW-1:0] s3_val_d;
    logic                 s3_sat_d;

    always_comb begin
        acc_sum  = $signed({acc_q[AW-1], acc_q}) + $signed({s2_raw[AW-1], s2_raw});
        acc_ovf  = acc_sum[AW] != acc_sum[AW-1];
        acc_new  = acc_ovf ? (acc_sum[AW] ? AccMin : AccMax) : acc_sum[AW-1:0];
        s3_val_d = s2_raw;
        s3_sat_d = s2_sat;
        if (s2_op == OpMac) begin
            s3_val_d = acc_new;
            s3_sat_d = acc_ovf;
        end else if (s2_op == OpAccRdClr) begin
            s3_val_d = acc_q;
        end
    end

    logic                 s3_valid;
    logic signed [AW-1:0] s3_val;
    kind_e                s3_kind;
    logic                 s3_sat, s3_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_val   <= '0;
            s3_kind  <= KindPass;
            s3_sat   <= 1'b0;
            s3_err   <= 1'b0;
            acc_q    <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_val  <= s3_val_d;
                s3_kind <= s2_kind;
                s3_sat  <= s3_sat_d;
                s3_err  <= s2_err;
                // Exactly one accumulator update per advancing bundle.
                if (s2_op == OpMac)      acc_q <= acc_new;
                if (s2_op == OpAccRdClr) acc_q <= '0;
            end
        end
    end

    // ---------------- Output: round and saturate ----------------
    logic signed [AW:0]  rnd, wide_v;
    logic [WIDTH-1:0]    res_d;
    logic                sat_d;

    always_comb begin
        rnd    = $signed({s3_val[AW-1], s3_val}) + Half;
        wide_v = (s3_kind == KindRound) ? (rnd >>> FRAC) : $signed({s3_val[AW-1], s3_val});
        res_d  = s3_val[WIDTH-1:0];
        sat_d  = s3_sat;
        if (s3_kind != KindPass) begin
            if (wide_v > WMaxWide) begin
                res_d = WMax;
                sat_d = 1'b1;
            end else if (wide_v < WMinWide) begin
                res_d = WMin;
                sat_d = 1'b1;
            end else begin
                res_d = wide_v[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
            err       <= 1'b0;
        end else if (adv) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                result <= res_d;
                sat    <= sat_d;
                err    <= s3_err;
            end
        end
    end

endmodule

// File: tb/tb_fxp_alu_pipe.sv
module tb_fxp_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, sat, err;
    logic [3:0]  op, shift;
    logic [15:0] a, b, result;

    fxp_alu_pipe #(.WIDTH(16), .FRAC(15), .SHIFT_W(4), .ACC_GUARD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] res;
        logic        s;
        logic        e;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        s;
        logic        e;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic obs[1:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %h, required no output", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("sat", 32'(sat), 32'(mon_e.s));
                check("err", 32'(err), 32'(mon_e.e));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [3:0] ss, input logic [15:0] r, input logic s,
                        input logic e, input bit track);
        bit done = 1'b0;
        op = o; a = aa; b = bb; shift = ss; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0, required 1");
        end else if (track) begin
            exp_q.push_back('{res: r, s: s, e: e});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; shift = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, out_valid after N+3 and not before.
        push(4'd1, 16'h2000, 16'h1000, 4'd0, 16'h3000, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            obs[k] = out_valid;
        end
        check("latency_n2", 32'(obs[3]), 32'd0);
        check("latency_n3", 32'(obs[4]), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Directed single-op vectors, issued back-to-back.
        vecs.push_back(vec_t'{4'd1,  16'h6000, 16'h4000, 4'd0,  16'h7FFF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd1,  16'h2000, 16'h1000, 4'd0,  16'h3000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd1,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd2,  16'h8000, 16'h0001, 4'd0,  16'h8000, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd2,  16'h7FFF, 16'h8000, 4'd0,  16'h7FFF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd2,  16'h0010, 16'h0001, 4'd0,  16'h000F, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3,  16'h4000, 16'h4000, 4'd0,  16'h2000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3,  16'h8000, 16'h8000, 4'd0,  16'h7FFF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd3,  16'hC000, 16'h4000, 4'd0,  16'hE000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3,  16'h0001, 16'h4000, 4'd0,  16'h0001, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3,  16'hFFFF, 16'h4000, 4'd0,  16'h0000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd7,  16'h2000, 16'h0000, 4'd2,  16'h7FFF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd7,  16'hF000, 16'h0000, 4'd3,  16'h8000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd7,  16'hC000, 16'h0000, 4'd2,  16'h8000, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd6,  16'h8000, 16'h0000, 4'd4,  16'hF800, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd6,  16'h7FFF, 16'h0000, 4'd15, 16'h0000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd11, 16'h8001, 16'h0000, 4'd1,  16'h0003, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd11, 16'h1234, 16'h0000, 4'd0,  16'h1234, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd12, 16'h0003, 16'h0000, 4'd1,  16'h8001, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd8,  16'hFF00, 16'h0FF0, 4'd0,  16'h0F00, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd9,  16'hFF00, 16'h0FF0, 4'd0,  16'hFFF0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd10, 16'hFF00, 16'h0FF0, 4'd0,  16'hF0F0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd14, 16'h1234, 16'h5678, 4'd0,  16'h0000, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd0,  16'h1234, 16'h5678, 4'd0,  16'h0000, 1'b0, 1'b0});
        foreach (vecs[i])
            push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res, vecs[i].s,
                 vecs[i].e, 1'b1);
        drain();

        // Back-to-back MAC chain, read-and-clear, then a fresh MAC.
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h2000, 1'b0, 1'b0, 1'b1);
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h4000, 1'b0, 1'b0, 1'b1);
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h6000, 1'b0, 1'b0, 1'b1);
        push(4'd5, 16'h0000, 16'h0000, 4'd0, 16'h6000, 1'b0, 1'b0, 1'b1);
        push(4'd4, 16'h2000, 16'h4000, 4'd0, 16'h1000, 1'b0, 1'b0, 1'b1);
        push(4'd5, 16'h0000, 16'h0000, 4'd0, 16'h1000, 1'b0, 1'b0, 1'b1);
        drain();

        // Stall: four ops in flight, downstream refuses for five cycles.
        out_ready = 1'b0;
        push(4'd1,  16'h0001, 16'h0001, 4'd0, 16'h0002, 1'b0, 1'b0, 1'b1);
        push(4'd2,  16'h0010, 16'h0001, 4'd0, 16'h000F, 1'b0, 1'b0, 1'b1);
        push(4'd10, 16'hFF00, 16'h0FF0, 4'd0, 16'hF0F0, 1'b0, 1'b0, 1'b1);
        push(4'd8,  16'hFF00, 16'h0FF0, 4'd0, 16'h0F00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'(result), 32'h0002);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset with two MACs in flight and a nonzero accumulator.
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h2000, 1'b0, 1'b0, 1'b1);
        drain();
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        push(4'd4, 16'h4000, 16'h4000, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("flushed_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push(4'd5, 16'h0000, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
